buffer_arbiter: RTL



---
 rtl/usb_buffer_pkg.sv | 18 +
 rtl/buffer_pointer.sv | 43 ++++
 rtl/buffer_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_buffer_pkg.sv
// ---------------------------------------------------------------------------
// usb_buffer_pkg
// Shared definitions for the USB data buffer: default geometry and the
// buffer direction mode. Used by buffer_arbiter, the protocol controller and
// the AHB slave so that all of them agree on the mode encoding.
// ---------------------------------------------------------------------------
package usb_buffer_pkg;

  localparam int BUF_DEPTH  = 64;
  localparam int BUF_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_MODE = 2'd1,
    TX_MODE = 2'd2
  } buf_mode_t;

endpackage

// File: rtl/buffer_pointer.sv
// ---------------------------------------------------------------------------
// buffer_pointer
// ADDR_W-bit wrapping pointer. The pointer wraps naturally because the buffer
// depth is a power of two.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   clr_i  : synchronous clear to 0 (wins over inc_i)
//   inc_i  : advance by one
//   ptr_o  : current pointer value
// ---------------------------------------------------------------------------
module buffer_pointer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/buffer_arbiter.sv
// ---------------------------------------------------------------------------
// buffer_arbiter
// Owns the single-port USB data buffer and shares it between USB RX (writes),
// USB TX (reads) and the AHB slave (reads and writes). Holds the read/write
// pointers, the occupancy count and the direction mode (buf_mode, which is
// also the state of the mode FSM and doubles as its debug view).
//
// Request/accept semantics: USB requests are single-cycle pulses that are
// always consumed in the cycle they appear (legal, erroneous or dropped).
// AHB requests are level requests held by the AHB slave; a request is taken
// in a cycle where it is present and ahb_stall is low, and must stay asserted
// while ahb_stall is high. Reads return *_rd_valid one cycle after being
// taken.
//
// Ports:
//   clk, rst, clear                      clock, sync reset, flush
//   rx_wr_req/rx_wr_data                 USB RX byte write
//   tx_rd_req/tx_rd_data/tx_rd_valid     USB TX byte read
//   ahb_wr_req/ahb_wr_data               AHB byte write
//   ahb_rd_req/ahb_rd_data/ahb_rd_valid  AHB byte read
//   ahb_stall                            AHB request present, not taken
//   buf_we/buf_addr/buf_wdata/buf_rdata  buffer RAM port (1-cycle read)
//   buffer_occupancy, buf_mode           bytes held, direction mode
//   overflow/underflow/dir_error         single-cycle error pulses
// ---------------------------------------------------------------------------
module buffer_arbiter
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH  = BUF_DEPTH,
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              rx_wr_req,
  input  logic [7:0]        rx_wr_data,
  input  logic              tx_rd_req,
  output logic [7:0]        tx_rd_data,
  output logic              tx_rd_valid,
  input  logic              ahb_wr_req,
  input  logic [7:0]        ahb_wr_data,
  input  logic              ahb_rd_req,
  output logic [7:0]        ahb_rd_data,
  output logic              ahb_rd_valid,
  output logic              ahb_stall,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  input  logic [7:0]        buf_rdata,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic [1:0]        buf_mode,
  output logic              overflow,
  output logic              underflow,
  output logic              dir_error
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

  buf_mode_t         mode_q, mode_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              dir_q, dir_d;
  logic              tx_vld_q, tx_vld_d;
  logic              tx_err_q, tx_err_d;
  logic              ahb_vld_q, ahb_vld_d;
  logic              ahb_err_q, ahb_err_d;

  logic              flush;
  logic              full;
  logic              wr_grant;
  logic              rd_grant;
  logic              wr_is_rx;
  logic              usb_busy;
  logic              ahb_rd_take;
  logic              ahb_wr_take;
  logic [7:0]        wdata;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  assign flush = rst | clear;
  assign full  = (occ_q == FULL_CNT);

  buffer_pointer #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear),
    .inc_i (wr_grant),
    .ptr_o (wr_ptr)
  );

  buffer_pointer #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clear),
    .inc_i (rd_grant),
    .ptr_o (rd_ptr)
  );

  // Arbitration. rx_wr and tx_rd can never both be legal (mode exclusive),
  // so at most one USB request needs the RAM. AHB only gets the slot when no
  // USB request is using it; an AHB read also outranks an AHB write.
  always_comb begin
    wr_grant    = 1'b0;
    rd_grant    = 1'b0;
    wr_is_rx    = 1'b0;
    wdata       = 8'h00;
    ovf_d       = 1'b0;
    unf_d       = 1'b0;
    dir_d       = 1'b0;
    tx_vld_d    = 1'b0;
    tx_err_d    = 1'b0;
    ahb_vld_d   = 1'b0;
    ahb_err_d   = 1'b0;
    ahb_rd_take = 1'b0;
    ahb_wr_take = 1'b0;
    usb_busy    = 1'b0;

    if (!flush) begin
      if (rx_wr_req) begin
        if (mode_q == TX_MODE) begin
          dir_d = 1'b1;
        end else if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_grant = 1'b1;
          wr_is_rx = 1'b1;
          wdata    = rx_wr_data;
        end
      end

      if (tx_rd_req) begin
        tx_vld_d = 1'b1;
        if (mode_q == IDLE) begin
          unf_d    = 1'b1;
          tx_err_d = 1'b1;
        end else if (mode_q == RX_MODE) begin
          dir_d    = 1'b1;
          tx_err_d = 1'b1;
        end else begin
          rd_grant = 1'b1;
        end
      end

      usb_busy = wr_grant | rd_grant;

      if (ahb_rd_req) begin
        if (!usb_busy) begin
          ahb_rd_take = 1'b1;
          ahb_vld_d   = 1'b1;
          if (mode_q == IDLE) begin
            unf_d     = 1'b1;
            ahb_err_d = 1'b1;
          end else if (mode_q == TX_MODE) begin
            dir_d     = 1'b1;
            ahb_err_d = 1'b1;
          end else begin
            rd_grant = 1'b1;
          end
        end
      end else if (ahb_wr_req) begin
        if (!usb_busy) begin
          ahb_wr_take = 1'b1;
          if (mode_q == RX_MODE) begin
            dir_d = 1'b1;
          end else if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_grant = 1'b1;
            wdata    = ahb_wr_data;
          end
        end
      end
    end
  end

  // Occupancy and mode FSM. Only one RAM access per cycle, so occupancy
  // moves by at most one in either direction.
  always_comb begin
    occ_d  = occ_q;
    mode_d = mode_q;
    if (flush) begin
      occ_d  = '0;
      mode_d = IDLE;
    end else if (wr_grant) begin
      occ_d = occ_q + ONE_CNT;
      if (mode_q == IDLE) begin
        mode_d = wr_is_rx ? RX_MODE : TX_MODE;
      end
    end else if (rd_grant) begin
      occ_d = occ_q - ONE_CNT;
      if (occ_q == ONE_CNT) begin
        mode_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= IDLE;
      occ_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      dir_q     <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_err_q  <= 1'b0;
      ahb_vld_q <= 1'b0;
      ahb_err_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      occ_q     <= occ_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      dir_q     <= dir_d;
      tx_vld_q  <= tx_vld_d;
      tx_err_q  <= tx_err_d;
      ahb_vld_q <= ahb_vld_d;
      ahb_err_q <= ahb_err_d;
    end
  end

  assign ahb_stall = flush ? (ahb_rd_req | ahb_wr_req)
                           : ((ahb_rd_req & ~ahb_rd_take) | (ahb_wr_req & ~ahb_wr_take));

  assign buf_we    = wr_grant;
  assign buf_addr  = wr_grant ? wr_ptr : (rd_grant ? rd_ptr : '0);
  assign buf_wdata = wdata;

  // Error reads never touched the RAM, so their data is forced to zero.
  assign tx_rd_valid  = tx_vld_q;
  assign tx_rd_data   = (tx_vld_q && !tx_err_q) ? buf_rdata : 8'h00;
  assign ahb_rd_valid = ahb_vld_q;
  assign ahb_rd_data  = (ahb_vld_q && !ahb_err_q) ? buf_rdata : 8'h00;

  assign buffer_occupancy = occ_q;
  assign buf_mode         = mode_q;
  assign overflow         = ovf_q;
  assign underflow        = unf_q;
  assign dir_error        = dir_q;

endmodule
